// File: rtl/apb_regfile_completer.sv
// apb_regfile_completer: APB completer exposing NUM_REGS word registers with
// a fixed number of wait states per transfer and an error response for
// unaligned or out-of-range addresses.
// Optional feature macro: APB_PSTRB_EN adds the PSTRB port and byte-lane writes.
module apb_regfile_completer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int         STRB_W     = DATA_WIDTH / 8;
    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WAIT_L     = 4'(WAIT_CYCLES);
    localparam logic [8:0] NUM_REGS_L = 9'(NUM_REGS);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state;
    logic [3:0]              wcnt;

    // Transfer attributes captured in the setup phase
    logic [7:0]              idx_q;
    logic [1:0]              lsb_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [STRB_W-1:0]       strb_in;
    logic                    setup_phase;
    logic                    access_phase;
    logic                    addr_ok;
    logic                    rd_strb_err;
    logic                    xfer_err;
    logic                    wr_commit;
    logic [DATA_WIDTH-1:0]   rd_word;

`ifdef APB_PSTRB_EN
    assign strb_in     = PSTRB;
    // A read carrying any strobe is a protocol error
    assign rd_strb_err = !write_q && (strb_q != '0);
`else
    assign strb_in     = '1;
    assign rd_strb_err = 1'b0;
`endif

    // Address bits above the register window are ignored by decode
    if (ADDR_WIDTH > 10) begin : g_upper_addr
        logic unused_addr_bits;
        assign unused_addr_bits = ^PADDR[ADDR_WIDTH-1:10];
    end

    assign setup_phase  = (state == IDLE) && PSEL && !PENABLE;
    assign access_phase = (state == ACCESS) && PSEL && PENABLE;

    assign addr_ok  = (lsb_q == 2'b00) && ({1'b0, idx_q} < NUM_REGS_L);
    assign xfer_err = !addr_ok || rd_strb_err;

    // Completion is combinational so zero wait states finish in the first access cycle
    assign PREADY    = access_phase && (wcnt == WAIT_L);
    assign PSLVERR   = PREADY && xfer_err;
    assign wr_commit = PREADY && write_q && !xfer_err;

    assign rd_word = regs[idx_q[IDX_W-1:0]];
    assign PRDATA  = (PREADY && !write_q && !xfer_err) ? rd_word : '0;

    // Control FSM: setup moves to ACCESS, completion or abort returns to IDLE
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state <= ACCESS;
                        wcnt  <= '0;
                    end
                end
                ACCESS: begin
                    if (!(PSEL && PENABLE)) begin
                        state <= IDLE;
                    end else if (PREADY) begin
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    // Capture address, direction, data and strobes during the setup phase
    always_ff @(posedge PCLK) begin
        if (setup_phase) begin
            idx_q   <= PADDR[9:2];
            lsb_q   <= PADDR[1:0];
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= strb_in;
        end
    end

    // Register file: clear on reset, byte-lane update on the completing edge
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    regs[idx_q[IDX_W-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: two instances (one and zero wait states),
// a fixed vector table, directed corner sequences and random traffic checked
// against a word-array model of the register file.
module tb_apb_regfile_completer;

    localparam int NREG = 16;
`ifdef APB_PSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel_a, psel_b, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  pstrb;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [2][NREG];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t vecs [13];

    always #5 PCLK = ~PCLK;

    apb_regfile_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG), .WAIT_CYCLES(1)) u_dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

    apb_regfile_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG), .WAIT_CYCLES(0)) u_dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic cur_ready(input bit b);
        return b ? pready_b : pready_a;
    endfunction
    function automatic logic cur_err(input bit b);
        return b ? pslverr_b : pslverr_a;
    endfunction
    function automatic logic [31:0] cur_rdata(input bit b);
        return b ? prdata_b : prdata_a;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NREG; i++) mdl[d][i] = '0;
    endtask

    task automatic model_write(input bit b, input int idx, input logic [31:0] data, input logic [3:0] strb);
        for (int i = 0; i < 4; i++)
            if (!STRB_EN || strb[i]) mdl[int'(b)][idx][8*i +: 8] = data[8*i +: 8];
    endtask

    // One APB transfer; leaves PSEL/PENABLE high so the next call can follow back-to-back
    task automatic apb_xfer(input bit b, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        int waits;
        bit noisy;
        @(negedge PCLK);
        psel_a = !b; psel_b = b; PENABLE = 1'b0;
        PADDR = addr; PWRITE = wr; PWDATA = wdata; pstrb = strb;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        waits = 0;
        noisy = 1'b0;
        while (!cur_ready(b) && waits < 40) begin
            if (cur_err(b) || cur_rdata(b) != 0) noisy = 1'b1;
            @(negedge PCLK);
            #1;
            waits++;
        end
        if (waits >= 40) begin
            total++;
            bad++;
            $display("FAIL pready_timeout: got no PREADY within %0d cycles", waits);
        end else begin
            check("wait_states", 32'(waits), b ? 32'd0 : 32'd1);
        end
        check("wait_outputs_quiet", 32'(noisy), 32'd0);
        rdata = cur_rdata(b);
        err   = cur_err(b);
    endtask

    task automatic go_idle();
        @(negedge PCLK);
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
        #1;
        check("idle_prdata", prdata_a | prdata_b, 32'd0);
        check("idle_flags", {30'd0, pready_a | pready_b, pslverr_a | pslverr_b}, 32'd0);
    endtask

    // Transfer checked against the model's view of the register file
    task automatic do_xfer(input bit b, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input string name);
        logic [31:0] rd, exp_rd;
        logic        er;
        int          idx;
        bit          e;
        idx = int'(addr[9:2]);
        e = (addr[1:0] != 2'b00) || (idx >= NREG) || (STRB_EN && !wr && strb != 4'h0);
        exp_rd = '0;
        if (!wr && !e) exp_rd = mdl[int'(b)][idx];
        apb_xfer(b, wr, addr, data, strb, rd, er);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, 32'(er), 32'(e));
        if (wr && !e) model_write(b, idx, data, strb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;

        vecs[0]  = '{1'b1, 32'h08,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h08,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h40,  32'h12345678, 32'h0,        1'b1};
        vecs[3]  = '{1'b1, 32'h05,  32'hCAFEF00D, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'h04,  32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h3C,  32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h40,  32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h3C,  32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h3C,  32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[9]  = '{1'b0, 32'h06,  32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h08,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[11] = '{1'b1, 32'h410, 32'h0BADF00D, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h10,  32'h0,        32'h0BADF00D, 1'b0};

        PRESET = 1'b1; psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
        PADDR = '0; PWRITE = 1'b0; PWDATA = '0; pstrb = '0;
        repeat (3) @(negedge PCLK);
        #1;
        check("reset_prdata", prdata_a | prdata_b, 32'd0);
        check("reset_flags", {30'd0, pready_a | pready_b, pslverr_a | pslverr_b}, 32'd0);
        PRESET = 1'b0;
        model_reset();

        // Access phase without a preceding setup is ignored
        @(negedge PCLK);
        psel_a = 1'b1; PENABLE = 1'b1; PADDR = 32'h08; PWRITE = 1'b1; PWDATA = 32'hFFFFFFFF; pstrb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(posedge PCLK);
            #1;
            check("nosetup_pready", 32'(pready_a), 32'd0);
        end
        go_idle();

        // Fixed vectors on the one-wait-state instance
        for (int i = 0; i < 13; i++) begin
            apb_xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].wr ? 4'hF : 4'h0, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            if (vecs[i].wr && !vecs[i].exp_err) model_write(1'b0, int'(vecs[i].addr[9:2]), vecs[i].data, 4'hF);
            if (i % 3 == 2) go_idle();
        end
        go_idle();
        for (int i = 0; i < NREG; i++) do_xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, 4'h0, "readback_a");
        go_idle();

        // Zero-wait-state back-to-back write then read
        do_xfer(1'b1, 1'b1, 32'h0, 32'h11, 4'hF, "b2b_wr");
        apb_xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        check("b2b_rd_rdata", rd, 32'h11);
        check("b2b_rd_err", 32'(er), 32'd0);
        go_idle();

        // PSEL dropped during the wait state of a write
        @(negedge PCLK);
        psel_a = 1'b1; PENABLE = 1'b0; PADDR = 32'h04; PWRITE = 1'b1; PWDATA = 32'h55; pstrb = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check("abort_wait_pready", 32'(pready_a), 32'd0);
        @(negedge PCLK);
        psel_a = 1'b0; PENABLE = 1'b0;
        #1;
        check("abort_pready", 32'(pready_a), 32'd0);
        apb_xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er);
        check("abort_rd_rdata", rd, 32'h0);
        go_idle();

        // Reset asserted in the completing access cycle of a write
        @(negedge PCLK);
        psel_a = 1'b1; PENABLE = 1'b0; PADDR = 32'h0C; PWRITE = 1'b1; PWDATA = 32'hFF; pstrb = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        #1;
        check("rst_mid_prdata", prdata_a, 32'd0);
        check("rst_mid_flags", {30'd0, pready_a, pslverr_a}, 32'd0);
        PRESET = 1'b0; psel_a = 1'b0; PENABLE = 1'b0;
        model_reset();
        apb_xfer(1'b0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
        check("rst_mid_rd_0c", rd, 32'h0);
        do_xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, "rst_mid_rd_08");
        do_xfer(1'b1, 1'b0, 32'h00, 32'h0, 4'h0, "rst_mid_rd_b00");
        go_idle();

`ifdef APB_PSTRB_EN
        do_xfer(1'b0, 1'b1, 32'h00, 32'hAABBCCDD, 4'b0101, "strb_wr");
        apb_xfer(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er);
        check("strb_rd_rdata", rd, 32'h00BB00DD);
        do_xfer(1'b0, 1'b1, 32'h00, 32'h12345678, 4'h0, "strb_none_wr");
        do_xfer(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, "strb_none_rd");
        do_xfer(1'b0, 1'b0, 32'h00, 32'h0, 4'h3, "strb_rd_err");
        go_idle();
`endif

        // Random traffic on both instances
        for (int n = 0; n < 300; n++) begin
            bit          b, wr;
            logic [31:0] addr;
            logic [3:0]  strb;
            b  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            addr = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'h0, 2'b00,
                    8'($urandom_range(0, 19)), 2'b00};
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            if (wr) strb = 4'($urandom);
            else    strb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_xfer(b, wr, addr, $urandom, strb, "rand");
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NREG; i++) do_xfer(1'(d), 1'b0, 32'(i * 4), 32'h0, 4'h0, "final_readback");
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
